instr_fetch_unit: RTL and testbench

Instruction fetch stage sitting between `target_program` (combinational code ROM) and the CPU decoder. Drives the ROM address from its program counter, assembles one- and two-word instructions (opcode plus immediate or branch-target extension word), and queues them in a 2-entry buffer presented to the decoder with a valid/ready handshake. Accepts jump/call/return redirects from the decoder and flushes in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: walks the code ROM from a program counter,
// assembles one- and two-word instructions and hands them to the decoder
// through a 2-entry buffer. Decoder redirects (jump/call/return) flush
// everything in flight and restart fetch at the new target.
//
// Handshake: the decoder consumes the buffer head on a rising edge where
// instr_valid && instr_ready are both high. instr_valid never depends
// combinationally on instr_ready, and the head outputs stay stable until
// they are consumed, a redirect flushes them, or reset clears them.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] code_addr,
  input  logic [15:0]           code_content,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [15:0]           instr_word,
  output logic [15:0]           instr_ext,
  output logic                  instr_has_ext,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic                  dbg_state_o
);

  typedef enum logic {
    FIRST = 1'b0,
    EXT   = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0]           word;
    logic [15:0]           ext;
    logic                  has_ext;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           stage_word_q, stage_word_d;
  logic [ADDR_WIDTH-1:0] stage_addr_q, stage_addr_d;
  entry_t                slot0_q, slot0_d;
  entry_t                slot1_q, slot1_d;
  logic [1:0]            count_q, count_d;

  logic                  pop;
  logic                  fetch_en;
  logic                  two_word;
  logic                  push;
  logic [1:0]            wr_idx;
  entry_t                push_entry;

  // Datapath decisions for this cycle: handshake, fetch enable, what to push.
  always_comb begin
    pop      = (count_q != 2'd0) && instr_ready;
    fetch_en = (count_q != 2'd2) || pop;
    two_word = (code_content[7:0] == 8'hA0) ||
               (code_content[15:12] == 4'hD) ||
               (code_content[15:12] == 4'hE);
    push     = fetch_en && ((state_q == EXT) || !two_word);
    wr_idx   = count_q - {1'b0, pop};
    push_entry = '0;
    if (state_q == EXT) begin
      push_entry.word    = stage_word_q;
      push_entry.ext     = code_content;
      push_entry.has_ext = 1'b1;
      push_entry.addr    = stage_addr_q;
    end else begin
      push_entry.word    = code_content;
      push_entry.ext     = 16'h0000;
      push_entry.has_ext = 1'b0;
      push_entry.addr    = pc_q;
    end
  end

  // Next-state logic: FSM, PC, staging register and buffer; redirect wins.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stage_word_d = stage_word_q;
    stage_addr_d = stage_addr_q;
    slot0_d      = slot0_q;
    slot1_d      = slot1_q;
    count_d      = count_q;

    if (jump_valid) begin
      // Flush: the handshake this cycle still counts for the decoder, but
      // the buffer is emptied and no new word is taken.
      pc_d    = jump_target;
      state_d = FIRST;
      count_d = 2'd0;
    end else begin
      if (fetch_en) begin
        pc_d = pc_q + PC_ONE;
        if (state_q == FIRST) begin
          stage_word_d = code_content;
          stage_addr_d = pc_q;
          if (two_word) state_d = EXT;
        end else begin
          state_d = FIRST;
        end
      end
      if (pop) slot0_d = slot1_q;
      if (push) begin
        if (wr_idx == 2'd0) slot0_d = push_entry;
        else                slot1_d = push_entry;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers with synchronous reset; reset also drops any staged opcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FIRST;
      pc_q         <= RESET_ADDR;
      stage_word_q <= 16'h0000;
      stage_addr_q <= '0;
      slot0_q      <= '0;
      slot1_q      <= '0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stage_word_q <= stage_word_d;
      stage_addr_q <= stage_addr_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      count_q      <= count_d;
    end
  end

  // All outputs come straight from registers.
  assign code_addr     = pc_q;
  assign instr_valid   = (count_q != 2'd0);
  assign instr_word    = slot0_q.word;
  assign instr_ext     = slot0_q.ext;
  assign instr_has_ext = slot0_q.has_ext;
  assign instr_addr    = slot0_q.addr;
  assign dbg_state_o   = (state_q == EXT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a ROM model drives code_content, a reference
// model walks the ROM as an instruction stream and queues expected
// instructions; a negedge monitor checks every accepted instruction.
module tb_instr_fetch_unit;

  localparam int AW = 16;

  logic          clk;
  logic          reset;
  logic [AW-1:0] code_addr;
  logic [15:0]   code_content;
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr_word;
  logic [15:0]   instr_ext;
  logic          instr_has_ext;
  logic [AW-1:0] instr_addr;
  logic          jump_valid;
  logic [AW-1:0] jump_target;
  logic          dbg_state;

  logic [15:0]   rom [0:65535];
  logic [48:0]   exp_q[$];
  logic [AW-1:0] model_pc;
  logic [48:0]   mon_got;
  logic [48:0]   mon_exp;
  int            n_vec;
  int            n_err;
  int            n_acc;
  int            acc_before;

  instr_fetch_unit #(.ADDR_WIDTH(AW), .RESET_ADDR(16'h0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .code_addr    (code_addr),
    .code_content (code_content),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_word   (instr_word),
    .instr_ext    (instr_ext),
    .instr_has_ext(instr_has_ext),
    .instr_addr   (instr_addr),
    .jump_valid   (jump_valid),
    .jump_target  (jump_target),
    .dbg_state_o  (dbg_state)
  );

  assign code_content = rom[code_addr];

  // Clock and reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_two_word(input logic [15:0] w);
    return (w[7:0] == 8'hA0) || (w[15:12] == 4'hD) || (w[15:12] == 4'hE);
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom());
    case ($urandom_range(0, 5))
      1: w[7:0]   = 8'hA0;
      2: w[15:12] = 4'hD;
      3: w[15:12] = 4'hE;
      4: w        = 16'hC800;
      5: w        = 16'hFC00;
      default: ;
    endcase
    return w;
  endfunction

  // Reference model: decode the next instruction of the program stream.
  task automatic gen_one();
    logic [15:0] w;
    logic [15:0] e;
    w = rom[model_pc];
    if (is_two_word(w)) begin
      e = rom[model_pc + 16'd1];
      exp_q.push_back({model_pc, 1'b1, e, w});
      model_pc = model_pc + 16'd2;
    end else begin
      exp_q.push_back({model_pc, 1'b0, 16'h0000, w});
      model_pc = model_pc + 16'd1;
    end
  endtask

  // Scoreboard monitor: compare each accepted instruction, then apply
  // flushes that take effect on the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_pc = 16'h0000;
    end else begin
      if (instr_valid && instr_ready) begin
        n_acc++;
        mon_got = {instr_addr, instr_has_ext, instr_ext, instr_word};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL instr: got %0h with no expected entry", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          check("instr{addr,has,ext,word}", 64'(mon_got), 64'(mon_exp));
        end
      end
      if (jump_valid) begin
        exp_q.delete();
        model_pc = jump_target;
      end
    end
    while (exp_q.size() < 2) gen_one();
  end

  // Driver: hold reset, rewrite ROM words while the DUT is held.
  task automatic enter_reset();
    tick();
    reset       = 1'b1;
    jump_valid  = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic leave_reset();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_acc = 0;
    reset = 1'b1;
    instr_ready = 1'b0;
    jump_valid = 1'b0;
    jump_target = '0;
    for (int i = 0; i < 65536; i++) rom[i] = rand_word();

    // Phase A: basic stream, reset values, first-valid latency, classification.
    rom[0] = 16'h2601; rom[1] = 16'h0A00; rom[2] = 16'h0210;
    for (int i = 3; i < 14; i++) rom[i] = 16'hC800;
    rom[14] = 16'h0FA0; rom[15] = 16'h0039;
    rom[16] = 16'hE401; rom[17] = 16'h001E;
    rom[18] = 16'hD310; rom[19] = 16'h1FB0;
    rom[20] = 16'hFC00;
    for (int i = 21; i < 33; i++) rom[i] = 16'hC800;
    repeat (3) tick();
    instr_ready = 1'b1;
    reset = 1'b0;
    mid();
    check("rst_code_addr", 64'(code_addr), 64'h0);
    check("rst_valid", 64'(instr_valid), 64'h0);
    check("rst_word", 64'(instr_word), 64'h0);
    check("rst_ext", 64'(instr_ext), 64'h0);
    check("rst_has_ext", 64'(instr_has_ext), 64'h0);
    check("rst_addr", 64'(instr_addr), 64'h0);
    tick();
    mid();
    check("first_valid", 64'(instr_valid), 64'h1);
    check("first_word", 64'(instr_word), 64'h2601);
    repeat (30) tick();

    // Phase B: backpressure with a single-word stream.
    enter_reset();
    for (int i = 0; i < 16; i++) rom[i] = 16'h2600 + 16'(i);
    leave_reset();
    repeat (11) tick();
    mid();
    check("bp_code_addr", 64'(code_addr), 64'h2);
    check("bp_valid", 64'(instr_valid), 64'h1);
    check("bp_head_addr", 64'(instr_addr), 64'h0);
    check("bp_head_word", 64'(instr_word), 64'h2600);
    tick();
    instr_ready = 1'b1;
    repeat (20) tick();

    // Phase C: reset while staging an opcode with one entry buffered.
    enter_reset();
    rom[0] = 16'hC800; rom[1] = 16'hE401; rom[2] = 16'h001E;
    for (int i = 3; i < 12; i++) rom[i] = 16'hC800;
    leave_reset();
    tick();
    tick();
    reset = 1'b1;
    mid();
    check("rc_in_ext", 64'(dbg_state), 64'h1);
    check("rc_one_buffered", 64'(instr_valid), 64'h1);
    tick();
    reset = 1'b0;
    instr_ready = 1'b1;
    mid();
    check("rc_valid", 64'(instr_valid), 64'h0);
    check("rc_code_addr", 64'(code_addr), 64'h0);
    check("rc_head", 64'({instr_addr, instr_has_ext, instr_ext, instr_word}), 64'h0);
    check("rc_state", 64'(dbg_state), 64'h0);
    repeat (15) tick();

    // Phase D: redirect while staging an extension word.
    enter_reset();
    rom[0] = 16'hC800; rom[1] = 16'h0FA0; rom[2] = 16'h0039; rom[3] = 16'hC800;
    rom[16'h2B] = 16'h13A0; rom[16'h2C] = 16'h30D4;
    leave_reset();
    tick();
    tick();
    jump_valid = 1'b1;
    jump_target = 16'h002B;
    mid();
    check("jd_in_ext", 64'(dbg_state), 64'h1);
    tick();
    jump_valid = 1'b0;
    instr_ready = 1'b1;
    mid();
    check("jd_flushed", 64'(instr_valid), 64'h0);
    check("jd_code_addr", 64'(code_addr), 64'h2B);
    tick();
    mid();
    check("jd_ext_wait", 64'(instr_valid), 64'h0);
    tick();
    mid();
    check("jd_valid", 64'(instr_valid), 64'h1);
    check("jd_head", 64'({instr_addr, instr_has_ext, instr_ext, instr_word}),
          64'({16'h002B, 1'b1, 16'h30D4, 16'h13A0}));
    repeat (10) tick();

    // Phase E: two-word instruction straddling the address wrap.
    enter_reset();
    rom[16'hFFFF] = 16'h07A0; rom[0] = 16'hF000; rom[1] = 16'hC800; rom[2] = 16'hC800;
    leave_reset();
    instr_ready = 1'b1;
    tick();
    jump_valid = 1'b1;
    jump_target = 16'hFFFF;
    tick();
    jump_valid = 1'b0;
    mid();
    check("wr_code_addr0", 64'(code_addr), 64'hFFFF);
    tick();
    mid();
    check("wr_code_addr1", 64'(code_addr), 64'h0);
    tick();
    mid();
    check("wr_head", 64'({instr_addr, instr_has_ext, instr_ext, instr_word}),
          64'({16'hFFFF, 1'b1, 16'hF000, 16'h07A0}));
    check("wr_code_addr2", 64'(code_addr), 64'h1);
    repeat (10) tick();

    // Phase F: random readiness, redirects and occasional resets.
    acc_before = n_acc;
    for (int c = 0; c < 3000; c++) begin
      tick();
      instr_ready = ($urandom_range(0, 9) < 7);
      jump_valid  = ($urandom_range(0, 24) == 0);
      jump_target = 16'($urandom());
      reset       = ($urandom_range(0, 399) == 0);
    end
    tick();
    reset = 1'b0;
    jump_valid = 1'b0;
    instr_ready = 1'b1;
    repeat (10) tick();
    check("rand_progress", 64'((n_acc - acc_before) > 500), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
